// File: rtl/multicycle_control.sv
// Multicycle MIPS controller: sequences fetch/decode/execute/memory/write-back
// and drives every datapath select and write enable for the current step.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     r_state;
    state_t     w_next;
    logic       w_iord;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [2:0] w_alu_control;
    logic [1:0] w_pc_src;
    logic       w_pc_write;
    logic       w_branch;
    logic       w_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and per-step datapath controls; unused selects stay at 0
    always_comb begin
        w_next        = r_state;
        w_iord        = 1'b0;
        w_mem_write   = 1'b0;
        w_ir_write    = 1'b0;
        w_reg_write   = 1'b0;
        w_reg_dst     = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_alu_src_a   = 1'b0;
        w_alu_src_b   = 2'b00;
        w_alu_control = 3'b000;
        w_pc_src      = 2'b00;
        w_pc_write    = 1'b0;
        w_branch      = 1'b0;
        w_illegal     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_alu_src_b   = 2'b01;
                w_alu_control = ALU_ADD;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                w_alu_src_b   = 2'b11;
                w_alu_control = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a   = 1'b1;
                w_alu_src_b   = 2'b10;
                w_alu_control = ALU_ADD;
                if (opcode == OP_LW) begin
                    w_next = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    w_next = S_MEMWR;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEMRD: begin
                w_iord = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWR: begin
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
                if (mem_ready) begin
                    w_next = S_FETCH;
                end
            end
            S_EXECUTE: begin
                w_alu_src_a = 1'b1;
                case (funct)
                    FN_SUB:  w_alu_control = ALU_SUB;
                    FN_AND:  w_alu_control = ALU_AND;
                    FN_OR:   w_alu_control = ALU_OR;
                    FN_SLT:  w_alu_control = ALU_SLT;
                    FN_ADD:  w_alu_control = ALU_ADD;
                    default: w_alu_control = ALU_ADD;
                endcase
                w_next = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a   = 1'b1;
                w_alu_control = ALU_SUB;
                w_branch      = 1'b1;
                w_pc_src      = 2'b01;
                w_next        = S_FETCH;
            end
            S_ADDIEX: begin
                w_alu_src_a   = 1'b1;
                w_alu_src_b   = 2'b10;
                w_alu_control = ALU_ADD;
                w_next        = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_JUMP: begin
                w_pc_src   = 2'b10;
                w_pc_write = 1'b1;
                w_next     = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Write enables and illegal are suppressed asynchronously while in reset
    assign ir_write    = w_ir_write  & rst_n;
    assign mem_write   = w_mem_write & rst_n;
    assign reg_write   = w_reg_write & rst_n;
    assign pc_en       = (w_pc_write | (w_branch & zero)) & rst_n;
    assign illegal     = w_illegal   & rst_n;
    assign iord        = w_iord;
    assign reg_dst     = w_reg_dst;
    assign mem_to_reg  = w_mem_to_reg;
    assign alu_src_a   = w_alu_src_a;
    assign alu_src_b   = w_alu_src_b;
    assign alu_control = w_alu_control;
    assign pc_src      = w_pc_src;
    assign state       = r_state;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Finite-state controller that sequences the shared MIPS datapath: ALU, register file, and a single unified instruction/data memory with a ready handshake. It replaces the single-cycle combinational control path. Each instruction is broken into fetch, decode, execute, memory and write-back steps, and the block drives every datapath select and write enable per step. It sits beside the datapath in the top-level, fed by the instruction register opcode/funct, the ALU zero flag and the memory ready signal.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instruction register bits [31:26]
- funct  in  6  instruction register bits [5:0]
- zero  in  1  ALU zero flag, valid during BEQ state
- mem_ready  in  1  memory completes the current access this cycle
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write enable
- ir_write  out  1  instruction register load
- reg_write  out  1  register file write enable
- reg_dst  out  1  write register: 0 = rt, 1 = rd
- mem_to_reg  out  1  write data: 0 = ALUOut, 1 = memory data register
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2
- alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- pc_en  out  1  PC load, equal to pc_write | (branch & zero)
- illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode
- state  out  4  current state code, for debug

## Operation
State codes and transitions:
- 0 FETCH: iord=0, alu_src_a=0, alu_src_b=01, add, pc_src=00. When mem_ready=1, ir_write=pc_write=1 and go to DECODE; otherwise stay.
- 1 DECODE: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Next state depends on opcode:
  - 100011 lw or 101011 sw → MEMADR
  - 000000 R-type → EXECUTE
  - 000100 beq → BRANCH
  - 001000 addi → ADDIEX
  - 000010 j → JUMP
  - anything else → FETCH with illegal=1
- 2 MEMADR: alu_src_a=1, alu_src_b=10, add. lw → MEMRD; sw → MEMWR.
- 3 MEMRD: iord=1. Hold until mem_ready, then go to MEMWB.
- 4 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, then FETCH.
- 5 MEMWR: iord=1, mem_write=1 for the whole state. Hold until mem_ready, then FETCH.
- 6 EXECUTE: alu_src_a=1, alu_src_b=00. ALU op from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other funct → add. Then ALUWB.
- 7 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
- 8 BRANCH: alu_src_a=1, alu_src_b=00, sub, branch=1, pc_src=01, then FETCH.
- 9 ADDIEX: alu_src_a=1, alu_src_b=10, add, then ADDIWB.
- 10 ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, then FETCH.
- 11 JUMP: pc_src=10, pc_write=1, then FETCH.
- Codes 12–15 are unreachable. If entered, go to FETCH with all enables low.

Output defaults:
- Every enable not listed for a state is 0.
- Don't-care selects are driven to 0.
- Outputs are Moore on state, except ir_write/pc_write (FETCH, gated by mem_ready), pc_en and alu_control (funct).

## Timing
- rst_n low: state=0 immediately, asynchronously. While rst_n is low, all write enables (ir_write, pc_en, reg_write, mem_write) are forced to 0 and illegal=0.
- The first FETCH is evaluated on the first rising edge after rst_n deasserts.
- Cycles per instruction with mem_ready held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle. Outputs are held stable during these waits.
- Reset asserted mid-instruction abandons it with no partial write, including a pending mem_write.
- The opcode is sampled only in DECODE and MEMADR, so the instruction register must hold it until FETCH.

## Test plan
- Reset: rst_n=0 mid-MEMWR → state=0 and mem_write=0 within the same cycle, with no clock edge. Release → FETCH outputs alu_src_b=01, alu_control=010.
- lw (opcode 100011), mem_ready=1 → states 0,1,2,3,4,0. reg_write=1 only in state 4, with mem_to_reg=1.
- sw with mem_ready low for 3 cycles in MEMWR → mem_write held 4 cycles, then FETCH. Total 7 cycles.
- R-type funct 100010 then 101010 → alu_control=110 then 111 in EXECUTE. reg_dst=1 in ALUWB.
- beq with zero=1 → pc_en=1, pc_src=01 in state 8. beq with zero=0 → pc_en=0.
- j → pc_en=1, pc_src=10 in state 11. Opcode 111111 → illegal pulses once in DECODE, then back to FETCH with no write.
